// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port (port B of a block RAM) between the CPU data port
// and the program loader. One access is in flight at a time and is carried
// through a three-state FSM:
//
//   IDLE   : nothing in flight; arbitrate incoming requests.
//   ACCESS : memory signals driven for one cycle; read data captured at the
//            end of the cycle.
//   RESP   : owner's rvalid pulses; a pending request may be accepted in the
//            same cycle, giving back-to-back accesses every two cycles.
//
// Ties are broken round-robin using a "loader was granted last" flag, which
// resets to 1 so that the CPU wins the first tie.
//
// Loader accesses whose upper address half equals MMIO_HI are rejected: the
// loader is still granted, the memory write enable is suppressed, and the
// response carries ldr_err=1 with rdata=0. CPU accesses are never filtered.
//
// Every output is driven straight from a register.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   cpu_req/we/addr/wdata         CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_rvalid           CPU accept / response pulses
//   ldr_req/we/addr/wdata         loader request (held until ldr_gnt)
//   ldr_gnt, ldr_rvalid, ldr_err  loader accept / response / reject pulses
//   rdata                         response data, shared by both requesters
//   mem_addr/wdata/we             memory port B request
//   mem_rdata                     memory port B read data
//   busy                          1 whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int          DATA_W  = 32,
    parameter logic [15:0] MMIO_HI = 16'hffff
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [DATA_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic              ldr_err,

    output logic [DATA_W-1:0] rdata,

    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    state_t            r_state;
    logic              r_last_ldr;   // 1: loader received the most recent grant
    logic              r_owner_ldr;  // owner of the access in flight
    logic              r_reject;     // access in flight is a rejected loader MMIO access
    logic              r_cpu_gnt;
    logic              r_ldr_gnt;
    logic              r_cpu_rvalid;
    logic              r_ldr_rvalid;
    logic              r_ldr_err;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_busy;

    // -----------------------------------------------------------------------
    // Next-state values
    // -----------------------------------------------------------------------
    state_t            w_state_next;
    logic              w_last_ldr_next;
    logic              w_owner_ldr_next;
    logic              w_reject_next;
    logic              w_cpu_gnt_next;
    logic              w_ldr_gnt_next;
    logic              w_cpu_rvalid_next;
    logic              w_ldr_rvalid_next;
    logic              w_ldr_err_next;
    logic [DATA_W-1:0] w_rdata_next;
    logic [DATA_W-1:0] w_mem_addr_next;
    logic [DATA_W-1:0] w_mem_wdata_next;
    logic              w_mem_we_next;
    logic              w_busy_next;

    // -----------------------------------------------------------------------
    // Arbitration helpers
    // -----------------------------------------------------------------------
    logic w_any_req;
    logic w_pick_ldr;
    logic w_ldr_mmio;

    assign w_any_req  = cpu_req | ldr_req;
    // Loader wins when it is alone, or when both request and the CPU was
    // granted last.
    assign w_pick_ldr = ldr_req & (~cpu_req | ~r_last_ldr);
    assign w_ldr_mmio = (ldr_addr[DATA_W-1 -: 16] == MMIO_HI);

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // Pulses default low; held values default to their current contents.
        w_state_next      = r_state;
        w_last_ldr_next   = r_last_ldr;
        w_owner_ldr_next  = r_owner_ldr;
        w_reject_next     = r_reject;
        w_cpu_gnt_next    = 1'b0;
        w_ldr_gnt_next    = 1'b0;
        w_cpu_rvalid_next = 1'b0;
        w_ldr_rvalid_next = 1'b0;
        w_ldr_err_next    = 1'b0;
        w_rdata_next      = r_rdata;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;
        w_mem_we_next     = 1'b0;

        case (r_state)
            ST_ACCESS: begin
                // Memory has seen the request for a full cycle; latch its
                // answer. Rejected loader accesses return zero instead.
                w_rdata_next      = r_reject ? '0 : mem_rdata;
                w_cpu_rvalid_next = ~r_owner_ldr;
                w_ldr_rvalid_next = r_owner_ldr;
                w_ldr_err_next    = r_reject;
                w_state_next      = ST_RESP;
            end

            ST_IDLE, ST_RESP: begin
                if (w_any_req) begin
                    w_state_next     = ST_ACCESS;
                    w_owner_ldr_next = w_pick_ldr;
                    w_last_ldr_next  = w_pick_ldr;
                    w_cpu_gnt_next   = ~w_pick_ldr;
                    w_ldr_gnt_next   = w_pick_ldr;
                    w_reject_next    = w_pick_ldr & w_ldr_mmio;
                    if (w_pick_ldr) begin
                        w_mem_addr_next  = ldr_addr;
                        w_mem_wdata_next = ldr_wdata;
                        w_mem_we_next    = ldr_we & ~w_ldr_mmio;
                    end else begin
                        w_mem_addr_next  = cpu_addr;
                        w_mem_wdata_next = cpu_wdata;
                        w_mem_we_next    = cpu_we;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // busy is registered alongside the state so it lines up with it.
        w_busy_next = (w_state_next != ST_IDLE);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // Aborts any access in flight: no response is ever issued for it.
            r_state      <= ST_IDLE;
            r_last_ldr   <= 1'b1;
            r_owner_ldr  <= 1'b0;
            r_reject     <= 1'b0;
            r_cpu_gnt    <= 1'b0;
            r_ldr_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_ldr_rvalid <= 1'b0;
            r_ldr_err    <= 1'b0;
            r_rdata      <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_last_ldr   <= w_last_ldr_next;
            r_owner_ldr  <= w_owner_ldr_next;
            r_reject     <= w_reject_next;
            r_cpu_gnt    <= w_cpu_gnt_next;
            r_ldr_gnt    <= w_ldr_gnt_next;
            r_cpu_rvalid <= w_cpu_rvalid_next;
            r_ldr_rvalid <= w_ldr_rvalid_next;
            r_ldr_err    <= w_ldr_err_next;
            r_rdata      <= w_rdata_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_mem_we     <= w_mem_we_next;
            r_busy       <= w_busy_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cpu_gnt    = r_cpu_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign ldr_gnt    = r_ldr_gnt;
    assign ldr_rvalid = r_ldr_rvalid;
    assign ldr_err    = r_ldr_err;
    assign rdata      = r_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = r_mem_we;
    assign busy       = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Inputs are changed 1 ns after each
// rising edge and outputs are sampled at the same point, so every sample
// reflects the registers loaded by the preceding edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic              ldr_req;
    logic              ldr_we;
    logic [DATA_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic              ldr_rvalid;
    logic              ldr_err;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int n_checks;
    int n_errors;

    mem_port_arbiter #(
        .DATA_W  (DATA_W),
        .MMIO_HI (16'hffff)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .ldr_err    (ldr_err),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        ldr_req   = 1'b0;
        ldr_we    = 1'b0;
        ldr_addr  = '0;
        ldr_wdata = '0;
        mem_rdata = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_cpu_gnt",    {31'd0, cpu_gnt},    32'd0);
        check("rst_ldr_gnt",    {31'd0, ldr_gnt},    32'd0);
        check("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check("rst_ldr_rvalid", {31'd0, ldr_rvalid}, 32'd0);
        check("rst_ldr_err",    {31'd0, ldr_err},    32'd0);
        check("rst_mem_we",     {31'd0, mem_we},     32'd0);
        check("rst_mem_addr",   mem_addr,            32'd0);
        check("rst_mem_wdata",  mem_wdata,           32'd0);
        check("rst_rdata",      rdata,               32'd0);
        reset = 1'b0;
        tick();

        // ---------------- CPU read ----------------
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0000_0010;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        check("rd_cpu_gnt",    {31'd0, cpu_gnt},    32'd1);
        check("rd_ldr_gnt",    {31'd0, ldr_gnt},    32'd0);
        check("rd_mem_we",     {31'd0, mem_we},     32'd0);
        check("rd_mem_addr",   mem_addr,            32'h0000_0010);
        check("rd_busy",       {31'd0, busy},       32'd1);
        check("rd_rvalid_early", {31'd0, cpu_rvalid}, 32'd0);
        cpu_req = 1'b0;
        tick();
        check("rd_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        check("rd_ldr_rvalid", {31'd0, ldr_rvalid}, 32'd0);
        check("rd_rdata",      rdata,               32'hDEAD_BEEF);
        check("rd_gnt_gone",   {31'd0, cpu_gnt},    32'd0);
        mem_rdata = 32'h0101_0101;
        tick();
        check("rd_rvalid_end", {31'd0, cpu_rvalid}, 32'd0);
        check("rd_idle_busy",  {31'd0, busy},       32'd0);
        check("rd_rdata_hold", rdata,               32'hDEAD_BEEF);

        // ---------------- CPU write ----------------
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0000_0004;
        cpu_wdata = 32'h1234_5678;
        mem_rdata = 32'hA5A5_0001;
        tick();
        check("wr_cpu_gnt",    {31'd0, cpu_gnt},    32'd1);
        check("wr_mem_we",     {31'd0, mem_we},     32'd1);
        check("wr_mem_addr",   mem_addr,            32'h0000_0004);
        check("wr_mem_wdata",  mem_wdata,           32'h1234_5678);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        tick();
        check("wr_mem_we_off", {31'd0, mem_we},     32'd0);
        check("wr_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        check("wr_rdata",      rdata,               32'hA5A5_0001);
        tick();
        check("wr_idle_busy",  {31'd0, busy},       32'd0);

        // ---------------- loader MMIO write (rejected) ----------------
        ldr_req   = 1'b1;
        ldr_we    = 1'b1;
        ldr_addr  = 32'hFFFF_FC60;
        ldr_wdata = 32'hCAFE_0000;
        mem_rdata = 32'h5555_AAAA;
        tick();
        check("mmio_ldr_gnt",    {31'd0, ldr_gnt},    32'd1);
        check("mmio_cpu_gnt",    {31'd0, cpu_gnt},    32'd0);
        check("mmio_mem_we",     {31'd0, mem_we},     32'd0);
        ldr_req = 1'b0;
        ldr_we  = 1'b0;
        tick();
        check("mmio_ldr_rvalid", {31'd0, ldr_rvalid}, 32'd1);
        check("mmio_ldr_err",    {31'd0, ldr_err},    32'd1);
        check("mmio_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check("mmio_rdata",      rdata,               32'd0);
        check("mmio_mem_we2",    {31'd0, mem_we},     32'd0);
        tick();
        check("mmio_err_end",    {31'd0, ldr_err},    32'd0);

        // ---------------- loader normal read ----------------
        ldr_req   = 1'b1;
        ldr_we    = 1'b0;
        ldr_addr  = 32'h0000_0100;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        check("lrd_ldr_gnt",    {31'd0, ldr_gnt},    32'd1);
        check("lrd_mem_addr",   mem_addr,            32'h0000_0100);
        ldr_req = 1'b0;
        tick();
        check("lrd_ldr_rvalid", {31'd0, ldr_rvalid}, 32'd1);
        check("lrd_ldr_err",    {31'd0, ldr_err},    32'd0);
        check("lrd_rdata",      rdata,               32'h0BAD_F00D);
        tick();

        // ---------------- round robin from reset, both held ----------------
        do_reset();
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0000_0020;
        ldr_req   = 1'b1;
        ldr_we    = 1'b0;
        ldr_addr  = 32'h0000_0040;
        mem_rdata = 32'h0000_0011;
        for (int k = 1; k <= 8; k++) begin
            logic exp_ldr;
            logic is_gnt;
            tick();
            exp_ldr = (((k - 1) / 2) % 2) == 1;
            is_gnt  = (k % 2) == 1;
            check($sformatf("rr%0d_cpu_gnt", k),    {31'd0, cpu_gnt},    {31'd0, is_gnt & ~exp_ldr});
            check($sformatf("rr%0d_ldr_gnt", k),    {31'd0, ldr_gnt},    {31'd0, is_gnt & exp_ldr});
            check($sformatf("rr%0d_cpu_rvalid", k), {31'd0, cpu_rvalid}, {31'd0, ~is_gnt & ~exp_ldr});
            check($sformatf("rr%0d_ldr_rvalid", k), {31'd0, ldr_rvalid}, {31'd0, ~is_gnt & exp_ldr});
            check($sformatf("rr%0d_busy", k),       {31'd0, busy},       32'd1);
            if (is_gnt)
                check($sformatf("rr%0d_mem_addr", k), mem_addr,
                      exp_ldr ? 32'h0000_0040 : 32'h0000_0020);
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        tick();
        check("rr_idle_busy", {31'd0, busy}, 32'd0);

        // ---------------- back-to-back CPU reads ----------------
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0080;
        for (int k = 1; k <= 6; k++) begin
            logic is_gnt;
            mem_rdata = 32'hC000_0000 | k;
            tick();
            is_gnt = (k % 2) == 1;
            check($sformatf("b2b%0d_busy", k),       {31'd0, busy},       32'd1);
            check($sformatf("b2b%0d_cpu_gnt", k),    {31'd0, cpu_gnt},    {31'd0, is_gnt});
            check($sformatf("b2b%0d_cpu_rvalid", k), {31'd0, cpu_rvalid}, {31'd0, ~is_gnt});
            if (!is_gnt)
                check($sformatf("b2b%0d_rdata", k), rdata, 32'hC000_0000 | k);
        end
        cpu_req = 1'b0;
        tick();
        check("b2b_idle_busy", {31'd0, busy}, 32'd0);

        // ---------------- reset during ACCESS ----------------
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0000_0008;
        cpu_wdata = 32'h0000_BEEF;
        tick();
        check("abort_mem_we_on", {31'd0, mem_we}, 32'd1);
        reset   = 1'b1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        tick();
        check("abort_mem_we",     {31'd0, mem_we},     32'd0);
        check("abort_busy",       {31'd0, busy},       32'd0);
        check("abort_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        reset = 1'b0;
        tick();
        check("abort_no_rvalid",  {31'd0, cpu_rvalid}, 32'd0);
        check("abort_idle_busy",  {31'd0, busy},       32'd0);

        cpu_req   = 1'b1;
        cpu_addr  = 32'h0000_0030;
        mem_rdata = 32'h7777_8888;
        tick();
        check("post_cpu_gnt",    {31'd0, cpu_gnt},    32'd1);
        cpu_req = 1'b0;
        tick();
        check("post_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        check("post_rdata",      rdata,               32'h7777_8888);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_W, 32, data/address width
- MMIO_HI, 16'hffff, upper address half marking MMIO space
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on rising edge
- reset, in, 1, synchronous, active-high
- cpu_req, in, 1, CPU data-port request
- cpu_we, in, 1, CPU write (1) / read (0)
- cpu_addr, in, DATA_W, CPU byte address
- cpu_wdata, in, DATA_W, CPU write data
- cpu_gnt, out, 1, CPU request accepted (1-cycle pulse)
- cpu_rvalid, out, 1, CPU response valid (1-cycle pulse)
- ldr_req, in, 1, program-loader request
- ldr_we, in, 1, loader write/read
- ldr_addr, in, DATA_W, loader byte address
- ldr_wdata, in, DATA_W, loader write data
- ldr_gnt, out, 1, loader request accepted (1-cycle pulse)
- ldr_rvalid, out, 1, loader response valid (1-cycle pulse)
- ldr_err, out, 1, loader access rejected (1-cycle pulse, with ldr_rvalid)
- rdata, out, DATA_W, response data shared by both requesters
- mem_addr, out, DATA_W, to memory port B address
- mem_wdata, out, DATA_W, to memory port B write data
- mem_we, out, 1, to memory port B write enable
- mem_rdata, in, DATA_W, from memory port B read data
- busy, out, 1, 1 while state != IDLE
REQ-003 Clock and reset: one clock, clk; reset is synchronous and active-high.

Function
REQ-004 FSM states: IDLE, ACCESS, RESP; all outputs registered.
REQ-005 Arbitration happens in IDLE and RESP; requests with no free arbitration slot wait, and req/we/addr/wdata are held stable by the requester until gnt.
REQ-006 Single requester -> it wins; both -> the one not granted last wins (round-robin flag last_ldr); the flag updates on every grant.
REQ-007 On acceptance at edge N: winner's gnt=1 in cycle N+1; mem_addr/mem_wdata/mem_we loaded from winner; state -> ACCESS.
REQ-008 ACCESS (1 cycle): mem_* held stable; at the end of the cycle mem_rdata is captured into rdata; state -> RESP.
REQ-009 RESP: owner's rvalid=1 for exactly one cycle; mem_we=0; rdata held until the next RESP; if a request is pending, arbitrate (back-to-back to ACCESS), else -> IDLE.
REQ-010 Latency: acceptance edge to rvalid = 2 cycles; peak throughput 1 access per 2 cycles.
REQ-011 Write responses also pulse rvalid; rdata is then don't-care but must still be the captured mem_rdata.
REQ-012 Loader access with ldr_addr[31:16]==MMIO_HI: ldr_gnt is still given and mem_we is forced 0; in RESP, ldr_rvalid=1 and ldr_err=1, and rdata=0.
REQ-013 CPU MMIO addresses pass through unmodified; decoding belongs to downstream memory.
REQ-014 gnt and rvalid are never asserted to both requesters in the same cycle.
REQ-015 mem_we is 1 only in ACCESS, for a non-rejected write.

Reset
REQ-016 While reset is high at an edge: state=IDLE, all gnt/rvalid/ldr_err/mem_we=0, mem_addr/mem_wdata/rdata=0, last_ldr=1 (CPU wins first tie), busy=0.
REQ-017 Reset during ACCESS or RESP aborts the transaction: no rvalid is issued and mem_we=0 from the next cycle.

Verification
REQ-018 CPU read addr 0x0000_0010, mem_rdata=0xDEAD_BEEF -> cpu_gnt at N+1, mem_we=0, cpu_rvalid at N+2 with rdata=0xDEAD_BEEF.
REQ-019 Both requests from reset, held -> grant order CPU, LDR, CPU, LDR; rvalid every 2 cycles, never simultaneous.
REQ-020 Loader write to 0xFFFF_FC60 -> ldr_gnt=1, mem_we stays 0, ldr_rvalid=ldr_err=1 in RESP, rdata=0.
REQ-021 CPU write 0x0000_0004 <= 0x1234_5678 -> mem_we=1 exactly one cycle, mem_addr/mem_wdata match; cpu_rvalid 1 cycle later.
REQ-022 reset asserted during ACCESS -> next cycle mem_we=0, busy=0, no rvalid; a subsequent request completes normally.
REQ-023 Back-to-back CPU reads held high -> RESP re-arbitrates with no IDLE cycle; busy stays 1 throughout.
